tcni_mmio_bridge: RTL

Memory-mapped bridge on the DUT side of the CPU bus in the TCNI packet simulator. It decodes CPU word accesses into a small register window. CPU writes feed a TX word FIFO that drives the network port; words arriving from the network are buffered in an RX FIFO that the CPU reads. The bridge produces the CPU's `data_in` and `irq`.

---
 rtl/tcni_bridge_pkg.sv | 30 +++
 rtl/tcni_mmio_bridge_if.sv | 27 ++
 rtl/tcni_sync_fifo.sv | 57 +++++
 rtl/tcni_mmio_bridge.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tcni_bridge_pkg.sv
// Shared constants for the TCNI MMIO bridge: register offsets inside the
// 8-word window, STATUS bit positions and IRQ_EN bit positions.
package tcni_bridge_pkg;

  // Register offsets (word offset within the window)
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_TX_DATA = 3'd1;
  localparam logic [2:0] REG_RX_DATA = 3'd2;
  localparam logic [2:0] REG_RX_POP  = 3'd3;
  localparam logic [2:0] REG_IRQ_EN  = 3'd4;
  localparam logic [2:0] REG_ERR     = 3'd5;

  // STATUS bit positions
  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_RX_EMPTY     = 2;
  localparam int unsigned ST_RX_FULL      = 3;
  localparam int unsigned ST_OVF          = 4;
  localparam int unsigned ST_TX_COUNT_LSB = 8;
  localparam int unsigned ST_RX_COUNT_LSB = 16;

  // IRQ_EN bit positions
  localparam int unsigned IE_RX_NOT_EMPTY = 0;
  localparam int unsigned IE_TX_EMPTY     = 1;
  localparam int unsigned IE_OVF          = 2;

  // ERR (write-one-to-clear) bit positions
  localparam int unsigned ERR_OVF = 0;

endpackage

// File: rtl/tcni_mmio_bridge_if.sv
// CPU bus and network port signals of the TCNI MMIO bridge.
// master: CPU/network side; slave: the bridge.
interface tcni_mmio_bridge_if #(
  parameter int unsigned MEMORY_BUS_WIDTH = 32
);
  logic [MEMORY_BUS_WIDTH-3:0] addr_out;
  logic [MEMORY_BUS_WIDTH-1:0] data_out;
  logic [3:0]                  wb_out;
  logic [MEMORY_BUS_WIDTH-1:0] data_in;
  logic                        irq;
  logic [MEMORY_BUS_WIDTH-1:0] tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic [MEMORY_BUS_WIDTH-1:0] rx_data;
  logic                        rx_valid;
  logic                        rx_ready;

  modport master (
    output addr_out, data_out, wb_out, tx_ready, rx_data, rx_valid,
    input  data_in, irq, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  addr_out, data_out, wb_out, tx_ready, rx_data, rx_valid,
    output data_in, irq, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/tcni_sync_fifo.sv
// Synchronous word FIFO. Full/empty are judged on the state before the
// cycle: a push while full is taken only alongside a real pop, a pop while
// empty is ignored. The head reads 0 while empty.
module tcni_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_head  = w_empty ? '0 : r_mem[r_rptr];
endmodule

// File: rtl/tcni_mmio_bridge.sv
// TCNI MMIO bridge: decodes CPU word accesses into an 8-word register window,
// feeds a TX FIFO toward the network and buffers network words in an RX FIFO.
// Optional feature macro: TCNI_BRIDGE_IRQ_EN (interrupt logic and IRQ_EN
// register); when undefined irq is tied low and IRQ_EN reads 0.
module tcni_mmio_bridge
  import tcni_bridge_pkg::*;
#(
  parameter int unsigned                 MEMORY_BUS_WIDTH = 32,
  parameter int unsigned                 FIFO_DEPTH       = 8,
  parameter logic [MEMORY_BUS_WIDTH-3:0] BASE_ADDR        = '0
) (
  input logic               clock,
  input logic               reset,
  tcni_mmio_bridge_if.slave bus
);
  localparam int unsigned W  = MEMORY_BUS_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_hit;
  logic [2:0]    w_off;
  logic          w_wr;
  logic          w_rd;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_tx_count;
  logic [CW-1:0] w_rx_count;
  logic [W-1:0]  w_tx_head;
  logic [W-1:0]  w_rx_head;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [2:0]    w_irq_en;
  logic [W-1:0]  w_status;
  logic [W-1:0]  w_rdata;
  logic          r_ovf;
  logic [W-1:0]  r_data_in;

  assign w_hit = (bus.addr_out[W-3:3] == BASE_ADDR[W-3:3]);
  assign w_off = bus.addr_out[2:0];
  assign w_wr  = w_hit && (bus.wb_out != 4'h0);
  assign w_rd  = w_hit && (bus.wb_out == 4'h0);

  // Only a full-word write to TX_DATA pushes; partial writes are dropped
  assign w_tx_push = w_wr && (w_off == REG_TX_DATA) && (bus.wb_out == 4'hF);
  assign w_tx_pop  = !w_tx_empty && bus.tx_ready;
  assign w_rx_push = bus.rx_valid && !w_rx_full;
  assign w_rx_pop  = w_wr && (w_off == REG_RX_POP);

  // A rejected TX push is one made while full with no same-cycle pop
  assign w_ovf_set = w_tx_push && w_tx_full && !w_tx_pop;
  assign w_ovf_clr = w_wr && (w_off == REG_ERR) && bus.wb_out[0] && bus.data_out[ERR_OVF];

  tcni_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_wdata (bus.data_out),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count),
    .o_head  (w_tx_head)
  );

  tcni_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_wdata (bus.rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count),
    .o_head  (w_rx_head)
  );

  // Sticky overflow flag; a same-cycle set beats the clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef TCNI_BRIDGE_IRQ_EN
  logic [2:0] r_irq_en;
  logic       r_irq;

  // IRQ_EN register, written through byte lane 0 only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_irq_en <= '0;
    end else if (w_wr && (w_off == REG_IRQ_EN) && bus.wb_out[0]) begin
      r_irq_en <= bus.data_out[2:0];
    end
  end

  // Interrupt flop sampling the current registered FIFO/ovf state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_irq_en[IE_RX_NOT_EMPTY] & ~w_rx_empty) |
               (r_irq_en[IE_TX_EMPTY]     &  w_tx_empty) |
               (r_irq_en[IE_OVF]          &  r_ovf);
    end
  end

  assign w_irq_en = r_irq_en;
  assign bus.irq  = r_irq;
`else
  assign w_irq_en = '0;
  assign bus.irq  = 1'b0;
`endif

  // STATUS word assembled from current state
  always_comb begin
    w_status                            = '0;
    w_status[ST_TX_FULL]                = w_tx_full;
    w_status[ST_TX_EMPTY]               = w_tx_empty;
    w_status[ST_RX_EMPTY]               = w_rx_empty;
    w_status[ST_RX_FULL]                = w_rx_full;
    w_status[ST_OVF]                    = r_ovf;
    w_status[ST_TX_COUNT_LSB +: CW]     = w_tx_count;
    w_status[ST_RX_COUNT_LSB +: CW]     = w_rx_count;
  end

  // Read mux on pre-write state; misses, writes and unused offsets give 0
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_off)
        REG_STATUS:  w_rdata = w_status;
        REG_RX_DATA: w_rdata = w_rx_head;
        REG_IRQ_EN:  w_rdata = W'(w_irq_en);
        default:     w_rdata = '0;
      endcase
    end
  end

  // Registered read data, one cycle of latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data_in <= '0;
    end else begin
      r_data_in <= w_rdata;
    end
  end

  assign bus.data_in  = r_data_in;
  assign bus.tx_data  = w_tx_head;
  assign bus.tx_valid = !w_tx_empty;
  assign bus.rx_ready = !w_rx_full;
endmodule
